// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 panel driver with binary code modulation and an internal framebuffer.
// Each row pair is scanned once per bit plane; plane b is displayed for BASE_ON<<b cycles.
// Optional feature macro: DOUBLE_BUFFER_EN (front/back framebuffers, swap at frame boundary).
module hub75_bcm_driver #(
    parameter int unsigned COLS      = 32,
    parameter int unsigned ROWS      = 32,
    parameter int unsigned BPC       = 4,
    parameter int unsigned BLANK_CYC = 8,
    parameter int unsigned LATCH_CYC = 4,
    parameter int unsigned BASE_ON   = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         we,
    input  logic [$clog2(ROWS*COLS)-1:0] wr_adr,
    input  logic [3*BPC-1:0]             wr_rgb,
    input  logic                         swap,
    output logic [2:0]                   rgb_a,
    output logic [2:0]                   rgb_b,
    output logic [$clog2(ROWS/2)-1:0]    row_address,
    output logic                         outclk,
    output logic                         latch,
    output logic                         eo,
    output logic                         frame_done
);

    localparam int unsigned ADR_W   = $clog2(ROWS * COLS);
    localparam int unsigned ROW_W   = $clog2(ROWS / 2);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned PIX_W   = 3 * BPC;
    localparam int unsigned HALF    = (ROWS / 2) * COLS;
    localparam int unsigned BANK_W  = $clog2(HALF);
    localparam int unsigned PLN_W   = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned ON_MAX  = BASE_ON << (BPC - 1);
    localparam int unsigned CNT_MAX = (ON_MAX > BLANK_CYC) ?
                                      ((ON_MAX > LATCH_CYC) ? ON_MAX : LATCH_CYC) :
                                      ((BLANK_CYC > LATCH_CYC) ? BLANK_CYC : LATCH_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS / 2 - 1);
    localparam logic [PLN_W-1:0] PLANE_LAST = PLN_W'(BPC - 1);
    localparam logic [CNT_W-1:0] BLANK_M1   = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] LATCH_M1   = CNT_W'(LATCH_CYC - 1);
    localparam logic [ADR_W:0]   NPIX_EXT   = (ADR_W + 1)'(ROWS * COLS);
    localparam logic [ADR_W:0]   HALF_EXT   = (ADR_W + 1)'(HALF);
    localparam logic [ADR_W-1:0] HALF_ADR   = ADR_W'(HALF);

    typedef enum logic [2:0] {
        StShiftRd, StShiftSet, StShiftClk, StBlank, StLatch, StDisplay
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PLN_W-1:0]  plane_q, plane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  disp_m1;
    logic              frame_end_d;

    // Framebuffer ports: upper bank feeds rgb_a, lower bank feeds rgb_b.
    logic              wr_lo, wr_ok;
    logic [BANK_W-1:0] wr_idx, rd_idx;
    logic [PIX_W-1:0]  rd_a, rd_b;

    assign wr_lo   = ({1'b0, wr_adr} >= HALF_EXT);
    assign wr_ok   = we && ({1'b0, wr_adr} < NPIX_EXT);
    assign wr_idx  = wr_lo ? BANK_W'(wr_adr - HALF_ADR) : BANK_W'(wr_adr);
    assign rd_idx  = {row_q, col_q};
    assign disp_m1 = CNT_W'((BASE_ON << plane_q) - 1);

`ifdef DOUBLE_BUFFER_EN
    logic             front_q, pend_q;
    logic [PIX_W-1:0] mem_a [2][HALF];
    logic [PIX_W-1:0] mem_b [2][HALF];

    // Host writes land in the back buffer; the scan always reads the front buffer.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_lo) mem_a[~front_q][wr_idx] <= wr_rgb;
        if (wr_ok && wr_lo)  mem_b[~front_q][wr_idx] <= wr_rgb;
        rd_a <= mem_a[front_q][rd_idx];
        rd_b <= mem_b[front_q][rd_idx];
    end

    // Swap requests collapse into one pending flag, honoured in the frame_done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else if (frame_done) begin
            if (pend_q || swap) front_q <= ~front_q;
            pend_q <= 1'b0;
        end else if (swap) begin
            pend_q <= 1'b1;
        end
    end
`else
    logic             unused_swap;
    logic [PIX_W-1:0] mem_a [HALF];
    logic [PIX_W-1:0] mem_b [HALF];

    assign unused_swap = swap;

    // Single framebuffer; a read in the same cycle as a write returns the old word.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_lo) mem_a[wr_idx] <= wr_rgb;
        if (wr_ok && wr_lo)  mem_b[wr_idx] <= wr_rgb;
        rd_a <= mem_a[rd_idx];
        rd_b <= mem_b[rd_idx];
    end
`endif

    // Per-channel slices of the read words, indexed by the current plane.
    logic [BPC-1:0] a_r, a_g, a_b, b_r, b_g, b_b;
    assign a_r = rd_a[3*BPC-1:2*BPC];
    assign a_g = rd_a[2*BPC-1:BPC];
    assign a_b = rd_a[BPC-1:0];
    assign b_r = rd_b[3*BPC-1:2*BPC];
    assign b_g = rd_b[2*BPC-1:BPC];
    assign b_b = rd_b[BPC-1:0];

    // Scan sequencing: column shift, blank, latch, then plane-weighted display.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        plane_d = plane_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StShiftRd:  state_d = StShiftSet;
            StShiftSet: state_d = StShiftClk;
            StShiftClk: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    cnt_d   = BLANK_M1;
                    state_d = StBlank;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StShiftRd;
                end
            end
            StBlank: begin
                if (cnt_q == '0) begin
                    cnt_d   = LATCH_M1;
                    state_d = StLatch;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLatch: begin
                if (cnt_q == '0) begin
                    cnt_d   = disp_m1;
                    state_d = StDisplay;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDisplay: begin
                if (cnt_q == '0) begin
                    state_d = StShiftRd;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StShiftRd;
        endcase
    end

    // Next cycle is the final display cycle of the last plane of the last row pair.
    assign frame_end_d = (state_d == StDisplay) && (cnt_d == '0) &&
                         (plane_d == PLANE_LAST) && (row_d == ROW_LAST);

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StShiftRd;
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
        end
    end

    // Panel outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outclk      <= 1'b0;
            latch       <= 1'b0;
            eo          <= 1'b1;
            frame_done  <= 1'b0;
            row_address <= '0;
            rgb_a       <= '0;
            rgb_b       <= '0;
        end else begin
            outclk     <= (state_d == StShiftClk);
            latch      <= (state_d == StLatch);
            eo         <= (state_d != StDisplay);
            frame_done <= frame_end_d;
            if ((state_d == StLatch) && (state_q != StLatch)) row_address <= row_q;
            if (state_q == StShiftSet) begin
                rgb_a <= {a_r[plane_q], a_g[plane_q], a_b[plane_q]};
                rgb_b <= {b_r[plane_q], b_g[plane_q], b_b[plane_q]};
            end
        end
    end

endmodule
